inta_sequencer: RTL and testbench



---
 rtl/inta_sequencer.sv | 127 ++++++++++++
 tb/tb_inta_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inta_sequencer.sv
// CPU-side interrupt-acknowledge sequencer for a cascaded 8259 PIC pair.
// Synchronizes INT_Flag, issues the two-pulse active-low INTA cycle and captures the vector.
module inta_sequencer #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       INT_Flag,
  input  logic       intr_enable,
  input  logic [7:0] data_Bus,
  output logic       INTA,
  output logic [7:0] vector,
  output logic       vector_valid,
  input  logic       vector_ack,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE1,
    S_GAP,
    S_PULSE2,
    S_HOLD
  } state_e;

  localparam logic [3:0] PulseLoad = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GapLoad   = 4'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sync_q;
  logic       inta_q, inta_d;
  logic [7:0] vector_q, vector_d;
  logic       valid_q, valid_d;
  logic       int_s;

  // INT_Flag comes from another clock domain; only the second flop is ever observed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], INT_Flag};
    end
  end

  assign int_s = sync_q[1];

  // NOTE: every variable gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vector_d = vector_q;
    valid_d  = valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (int_s && intr_enable) begin
          state_d = S_PULSE1;
          cnt_d   = PulseLoad;
        end
      end
      S_PULSE1: begin
        if (cnt_q == 4'd0) begin
          state_d = S_GAP;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_PULSE2;
          cnt_d   = PulseLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_PULSE2: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_HOLD;
          vector_d = data_Bus;
          valid_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (vector_ack && valid_q) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // INTA is decoded from the next state so the registered pin changes on the same edge as the state.
    inta_d = !((state_d == S_PULSE1) || (state_d == S_PULSE2));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values;
  // the asynchronous reset forces INTA high straight from a flop, so it cannot glitch low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      inta_q   <= 1'b1;
      vector_q <= 8'h00;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      inta_q   <= inta_d;
      vector_q <= vector_d;
      valid_q  <= valid_d;
    end
  end

  assign INTA         = inta_q;
  assign vector       = vector_q;
  assign vector_valid = valid_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: default timing instance plus a PULSE=1/GAP=3 instance.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       INT_Flag, intr_enable, vector_ack;
  logic [7:0] data_Bus;
  logic       INTA, vector_valid, busy;
  logic [7:0] vector;

  logic       b_INT_Flag, b_intr_enable, b_vector_ack;
  logic [7:0] b_data_Bus;
  logic       b_INTA, b_vector_valid, b_busy;
  logic [7:0] b_vector;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inta_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .INT_Flag     (INT_Flag),
    .intr_enable  (intr_enable),
    .data_Bus     (data_Bus),
    .INTA         (INTA),
    .vector       (vector),
    .vector_valid (vector_valid),
    .vector_ack   (vector_ack),
    .busy         (busy)
  );

  inta_sequencer #(.PULSE_CYCLES(1), .GAP_CYCLES(3)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .INT_Flag     (b_INT_Flag),
    .intr_enable  (b_intr_enable),
    .data_Bus     (b_data_Bus),
    .INTA         (b_INTA),
    .vector       (b_vector),
    .vector_valid (b_vector_valid),
    .vector_ack   (b_vector_ack),
    .busy         (b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    INT_Flag      = 1'b0;
    intr_enable   = 1'b0;
    vector_ack    = 1'b0;
    data_Bus      = 8'h00;
    b_INT_Flag    = 1'b0;
    b_intr_enable = 1'b0;
    b_vector_ack  = 1'b0;
    b_data_Bus    = 8'h00;
    tick();
    tick();
    reset = 1'b0;

    check("rst_inta", INTA, 1);
    check("rst_vector", vector, 8'h00);
    check("rst_valid", vector_valid, 0);
    check("rst_busy", busy, 0);

    // Basic sequence with default timing, vector 4A.
    INT_Flag    = 1'b1;
    intr_enable = 1'b1;
    tick();  // E0
    check("t1_e0_inta", INTA, 1);
    tick();  // E1
    check("t1_e1_busy", busy, 0);
    tick();  // E2
    check("t1_e2_inta", INTA, 0);
    check("t1_e2_busy", busy, 1);
    INT_Flag = 1'b0;
    tick();  // E3
    check("t1_e3_inta", INTA, 0);
    tick();  // E4
    check("t1_e4_inta", INTA, 1);
    tick();  // E5
    check("t1_e5_inta", INTA, 1);
    data_Bus = 8'h4A;
    tick();  // E6
    check("t1_e6_inta", INTA, 0);
    tick();  // E7
    check("t1_e7_inta", INTA, 0);
    check("t1_e7_valid", vector_valid, 0);
    tick();  // E8
    check("t1_e8_inta", INTA, 1);
    check("t1_e8_valid", vector_valid, 1);
    check("t1_e8_vector", vector, 8'h4A);
    vector_ack = 1'b1;
    tick();  // E9
    check("t1_e9_valid", vector_valid, 0);
    check("t1_e9_busy", busy, 0);
    check("t1_e9_vector", vector, 8'h4A);
    vector_ack = 1'b0;
    data_Bus   = 8'h00;

    // Ack while idle has no effect.
    vector_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_idle_ack", {INTA, busy, vector_valid}, 3'b100);
    end
    check("t6_vector_kept", vector, 8'h4A);
    vector_ack = 1'b0;

    // Request pending while interrupts are disabled.
    INT_Flag    = 1'b1;
    intr_enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t2_disabled", {INTA, busy}, 2'b10);
    end
    intr_enable = 1'b1;
    tick();  // F: PULSE1 entered
    check("t2_start_inta", INTA, 0);
    check("t2_start_busy", busy, 1);
    INT_Flag = 1'b0;
    data_Bus = 8'hC5;
    repeat (5) tick();  // F+5: last cycle of pulse 2
    check("t2_pulse2_inta", INTA, 0);
    tick();  // F+6
    check("t2_valid", vector_valid, 1);
    check("t2_vector", vector, 8'hC5);
    check("t2_inta_hold", INTA, 1);
    vector_ack = 1'b1;
    tick();
    check("t2_ack_valid", vector_valid, 0);
    check("t2_ack_busy", busy, 0);
    vector_ack = 1'b0;
    data_Bus   = 8'h00;

    // INT_Flag dropped during the gap; second pulse still issued.
    INT_Flag = 1'b1;
    tick();  // E0
    tick();  // E1
    tick();  // E2
    check("t3_e2_inta", INTA, 0);
    tick();  // E3
    tick();  // E4
    check("t3_gap_inta", INTA, 1);
    INT_Flag = 1'b0;
    data_Bus = 8'h3F;
    tick();  // E5
    tick();  // E6
    check("t3_pulse2_inta", INTA, 0);
    tick();  // E7
    tick();  // E8
    check("t3_valid", vector_valid, 1);
    check("t3_vector", vector, 8'h3F);
    vector_ack = 1'b1;
    tick();
    vector_ack = 1'b0;
    repeat (3) tick();
    check("t3_idle_busy", busy, 0);
    check("t3_idle_valid", vector_valid, 0);

    // Reset pulsed during pulse 2 discards the capture.
    INT_Flag = 1'b1;
    tick();  // E0
    tick();  // E1
    tick();  // E2
    INT_Flag = 1'b0;
    data_Bus = 8'h77;
    repeat (4) tick();  // E6
    check("t4_in_pulse2", INTA, 0);
    #2 reset = 1'b1;
    #1;
    check("t4_rst_inta", INTA, 1);
    check("t4_rst_valid", vector_valid, 0);
    check("t4_rst_vector", vector, 8'h00);
    check("t4_rst_busy", busy, 0);
    #3 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_after_rst", {INTA, busy, vector_valid}, 3'b100);
    end
    check("t4_no_capture", vector, 8'h00);
    data_Bus = 8'h00;

    // PULSE_CYCLES=1, GAP_CYCLES=3, back-to-back with a delayed ack.
    b_INT_Flag    = 1'b1;
    b_intr_enable = 1'b1;
    tick();  // E0
    tick();  // E1
    check("t5_e1_inta", b_INTA, 1);
    tick();  // E2
    check("t5_e2_inta", b_INTA, 0);
    tick();  // E3
    check("t5_e3_inta", b_INTA, 1);
    tick();  // E4
    tick();  // E5
    check("t5_e5_inta", b_INTA, 1);
    b_data_Bus = 8'h08;
    tick();  // E6
    check("t5_e6_inta", b_INTA, 0);
    tick();  // E7
    check("t5_e7_inta", b_INTA, 1);
    check("t5_e7_valid", b_vector_valid, 1);
    check("t5_e7_vector", b_vector, 8'h08);
    b_data_Bus = 8'h09;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_hold", {b_INTA, b_busy, b_vector_valid}, 3'b111);
      check("t5_hold_vector", b_vector, 8'h08);
    end
    b_vector_ack = 1'b1;
    tick();  // ack edge N
    check("t5_ack_valid", b_vector_valid, 0);
    check("t5_ack_busy", b_busy, 0);
    b_vector_ack = 1'b0;
    tick();  // N+1
    check("t5_restart_inta", b_INTA, 0);
    b_INT_Flag = 1'b0;
    tick();  // N+2 gap
    check("t5_gap2_inta", b_INTA, 1);
    repeat (3) tick();  // N+5 pulse 2
    check("t5_pulse2b_inta", b_INTA, 0);
    tick();  // N+6
    check("t5_valid2", b_vector_valid, 1);
    check("t5_vector2", b_vector, 8'h09);
    b_vector_ack = 1'b1;
    tick();
    check("t5_ack2_valid", b_vector_valid, 0);
    b_vector_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
